serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. It time-shares one Full_Adder instance to add two DATA_WIDTH-bit operands, one bit per clock, LSB first. It sequences operand shifting, carry feedback and result assembly, and handshakes with a requester through Start_In, Ready_Out and Done_Out. It is the area-minimal alternative to a ripple-carry adder in the Basic_Arithmetic library.

Parameters:
DATA_WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  synchronous active-low reset, sampled on the Clk rising edge
Start_In  input  1  request; accepted only when Ready_Out=1
Data_A_In  input  DATA_WIDTH  operand A, sampled on the accepting edge
Data_B_In  input  DATA_WIDTH  operand B, sampled on the accepting edge
Carry_In  input  1  initial carry, sampled on the accepting edge
Ready_Out  output  1  high in IDLE only (combinational from state)
Busy_Out  output  1  high in ADD and DONE (combinational from state)
Sum_Out  output  DATA_WIDTH  registered result
Carry_Out  output  1  registered final carry
Done_Out  output  1  registered one-cycle pulse marking a new result

Behaviour:
- Reset (Reset_n=0 at an edge): state=IDLE; Sum_Out=0, Carry_Out=0, Done_Out=0; bit counter=0; shift and carry registers=0. Ready_Out=1, Busy_Out=0.
- Reset wins over all other events at the same edge.
- Reset mid-ADD or mid-DONE aborts the operation. No Done_Out pulse; outputs are cleared to 0.
- FSM has three states: IDLE, ADD, DONE.
- IDLE:
  - Start_In=1 at edge k loads the A/B shift registers with Data_A_In/Data_B_In, loads the carry register with Carry_In, sets counter=0 and moves to ADD.
  - Start_In=0: stay in IDLE.
- ADD, each edge:
  - The Full_Adder is fed A_sh[0], B_sh[0] and the carry register.
  - Its Sum_Out shifts into the MSB of the result shift register, which shifts right.
  - The carry register takes the Full_Adder Carry_Out.
  - A_sh and B_sh shift right; counter increments.
  - On the edge where counter==DATA_WIDTH-1:
    - Sum_Out is loaded with the completed result, including the final bit produced that cycle.
    - Carry_Out is loaded with the final carry.
    - Done_Out is set to 1 and the FSM moves to DONE.
- DONE: lasts one cycle. At the next edge Done_Out returns to 0 and the FSM moves to IDLE.
- Timing: edges k+1..k+DATA_WIDTH process bits 0..DATA_WIDTH-1. Done_Out is high from edge k+DATA_WIDTH to edge k+DATA_WIDTH+1. Ready_Out returns high after edge k+DATA_WIDTH+1.
- Throughput: with Start_In held high, one operation is accepted every DATA_WIDTH+2 cycles.
- Start_In while Ready_Out=0 is ignored and not queued. Input changes during ADD or DONE have no effect.
- Sum_Out and Carry_Out change only on DONE entry or reset. They hold the last result indefinitely and never show partial sums.
- Arithmetic: {Carry_Out, Sum_Out} = Data_A_In + Data_B_In + Carry_In, unsigned, exact in DATA_WIDTH+1 bits.
- DATA_WIDTH=1: one ADD cycle; Done_Out is asserted after edge k+1.

Optional Feature:
SERIAL_ADDER_OVERFLOW_EN
- Defined:
  - Adds output port Overflow_Out (1 bit, registered, reset 0).
  - Overflow_Out = (carry into the MSB stage) XOR (final carry out), i.e. two's-complement signed overflow.
  - It is loaded on DONE entry alongside Sum_Out and held with it.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then Start with A=0x0F, B=0x01, Cin=0 (W=8) -> Done_Out pulses 8 edges after acceptance for exactly 1 cycle; Sum_Out=0x10, Carry_Out=0; Ready_Out high one cycle later.
- A=0xFF, B=0x01, Cin=0 -> Sum_Out=0x00, Carry_Out=1. A=0xFF, B=0xFF, Cin=1 -> Sum_Out=0xFF, Carry_Out=1.
- Start accepted with A=0x12, B=0x34; pulse Start with A=0xFF, B=0xFF at ADD cycle 3 -> ignored; Sum_Out=0x46, Carry_Out=0; exactly one Done_Out pulse.
- Start A=0xAA, B=0x55; drive Reset_n=0 for one edge at ADD cycle 4 -> Sum_Out=0, Carry_Out=0, Done_Out never pulses, Ready_Out=1 next cycle; a new Start A=0x01, B=0x01 gives 0x02.
- Start held high with random A/B/Cin for 50 operations -> accepts every 10 cycles; each result matches the 9-bit reference sum; Sum_Out stable between Done pulses.
- With SERIAL_ADDER_OVERFLOW_EN: A=0x7F, B=0x01 -> Sum_Out=0x80, Overflow_Out=1. A=0xFF, B=0x01 -> Overflow_Out=0, Carry_Out=1. A=0x80, B=0x80 -> Sum_Out=0x00, Overflow_Out=1, Carry_Out=1.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// ============================================================================
// Module   : serial_adder_ctrl_if
// Brief    : Requester <-> serial adder handshake and result bus.
//            Overflow_Out exists only when SERIAL_ADDER_OVERFLOW_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_adder_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  Start_In;
  logic [DATA_WIDTH-1:0] Data_A_In;
  logic [DATA_WIDTH-1:0] Data_B_In;
  logic                  Carry_In;
  logic                  Ready_Out;
  logic                  Busy_Out;
  logic [DATA_WIDTH-1:0] Sum_Out;
  logic                  Carry_Out;
  logic                  Done_Out;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic                  Overflow_Out;

  modport master (
    output Start_In, Data_A_In, Data_B_In, Carry_In,
    input  Ready_Out, Busy_Out, Sum_Out, Carry_Out, Done_Out, Overflow_Out
  );
  modport slave (
    input  Start_In, Data_A_In, Data_B_In, Carry_In,
    output Ready_Out, Busy_Out, Sum_Out, Carry_Out, Done_Out, Overflow_Out
  );
`else
  modport master (
    output Start_In, Data_A_In, Data_B_In, Carry_In,
    input  Ready_Out, Busy_Out, Sum_Out, Carry_Out, Done_Out
  );
  modport slave (
    input  Start_In, Data_A_In, Data_B_In, Carry_In,
    output Ready_Out, Busy_Out, Sum_Out, Carry_Out, Done_Out
  );
`endif
endinterface

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// Module   : serial_adder_ctrl
// Brief    : Bit-serial adder controller, one shared full adder, LSB first.
//            Optional macro SERIAL_ADDER_OVERFLOW_EN adds Overflow_Out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input logic                Clk,
  input logic                Reset_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] a_sh;
  logic [DATA_WIDTH-1:0] b_sh;
  logic [DATA_WIDTH-1:0] res_sh;
  logic [DATA_WIDTH-1:0] res_next;
  logic                  carry_q;
  logic [CNT_W-1:0]      cnt;
  logic                  fa_sum;
  logic                  fa_cout;
  logic                  load_op;
  logic                  step;
  logic                  finish;
  logic                  ready;
  logic                  busy;

  full_adder u_full_adder (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // The new sum bit enters at the MSB so that after DATA_WIDTH steps bit 0 sits at the LSB.
  generate
    if (DATA_WIDTH > 1) begin : g_wide
      assign res_next = {fa_sum, res_sh[DATA_WIDTH-1:1]};
    end else begin : g_narrow
      assign res_next = fa_sum;
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_op    = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    ready      = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.Start_In) begin
          load_op    = 1'b1;
          state_next = ADD;
        end
      end
      ADD: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == LAST_BIT) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.Ready_Out = ready;
  assign bus.Busy_Out  = busy;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      a_sh          <= '0;
      b_sh          <= '0;
      res_sh        <= '0;
      carry_q       <= 1'b0;
      cnt           <= '0;
      bus.Sum_Out   <= '0;
      bus.Carry_Out <= 1'b0;
      bus.Done_Out  <= 1'b0;
    end else begin
      bus.Done_Out <= finish;
      if (load_op) begin
        a_sh    <= bus.Data_A_In;
        b_sh    <= bus.Data_B_In;
        carry_q <= bus.Carry_In;
        cnt     <= '0;
      end else if (step) begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        res_sh  <= res_next;
        carry_q <= fa_cout;
        cnt     <= cnt + 1'b1;
        if (finish) begin
          bus.Sum_Out   <= res_next;
          bus.Carry_Out <= fa_cout;
        end
      end
    end
  end

`ifdef SERIAL_ADDER_OVERFLOW_EN
  // On the final step carry_q still holds the carry into the MSB stage.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      bus.Overflow_Out <= 1'b0;
    end else if (finish) begin
      bus.Overflow_Out <= carry_q ^ fa_cout;
    end
  end
`endif

endmodule

`default_nettype wire
